// File: rtl/mod_entradas_if.sv
// Board-side input capture bus: raw switches, load button and clear in; latched code out.
interface mod_entradas_if;
  logic [3:0] sw;
  logic       btn;
  logic       clr;
  logic       A;
  logic       B;
  logic       C;
  logic       D;
  logic       ready;
  logic       load_pulse;

  modport master (
    output sw, btn, clr,
    input  A, B, C, D, ready, load_pulse
  );

  modport slave (
    input  sw, btn, clr,
    output A, B, C, D, ready, load_pulse
  );
endinterface

// File: rtl/mod_entradas.sv
// Synchronizes switches and load button, debounces the button and latches the
// switch code with a ready qualifier and a one-cycle load strobe.
//
// state   | meaning
// IDLE    | button released and stable
// PRESS   | counting consecutive high samples
// HELD    | press accepted, waiting for release
// RELEASE | counting consecutive low samples
module mod_entradas #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input logic          clk,
  input logic          reset,
  mod_entradas_if.slave bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  logic [1:0]       btn_sync_q;
  logic [3:0]       sw_meta_q;
  logic [3:0]       sw_s_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             latch;
  logic [3:0]       code_q, code_d;
  logic             ready_q, ready_d;
  logic             pulse_q, pulse_d;
  logic             btn_s;

  assign btn_s   = btn_sync_q[1];
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;

  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_sync_q <= '0;
      sw_meta_q  <= '0;
      sw_s_q     <= '0;
    end else begin
      btn_sync_q <= {btn_sync_q[0], bus.btn};
      sw_meta_q  <= bus.sw;
      sw_s_q     <= sw_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      ready_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      ready_q <= ready_d;
      pulse_q <= pulse_d;
    end
  end

  // With a single-sample debounce PRESS and RELEASE are bypassed entirely.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (btn_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = HELD;
            cnt_d   = '0;
            latch   = 1'b1;
          end else begin
            state_d = PRESS;
            cnt_d   = CNT_ONE;
          end
        end
      end
      PRESS: begin
        if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          latch   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        if (!btn_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = RELEASE;
            cnt_d   = CNT_ONE;
          end
        end
      end
      RELEASE: begin
        if (btn_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Clear beats a simultaneous latch; the FSM is left to advance on its own.
  always_comb begin
    code_d  = code_q;
    ready_d = ready_q;
    pulse_d = 1'b0;
    if (bus.clr) begin
      code_d  = '0;
      ready_d = 1'b0;
    end else if (latch) begin
      code_d  = sw_s_q;
      ready_d = 1'b1;
      pulse_d = 1'b1;
    end
  end

  assign bus.A          = code_q[3];
  assign bus.B          = code_q[2];
  assign bus.C          = code_q[1];
  assign bus.D          = code_q[0];
  assign bus.ready      = ready_q;
  assign bus.load_pulse = pulse_q;

endmodule
